mandelbrot_pixel_buffer: RTL

MANDELBROT_PIXEL_BUFFER -- requirements
Module: mandelbrot_pixel_buffer

---
 rtl/mandelbrot_pixel_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/mandelbrot_pixel_buffer.sv
// Pixel FIFO between a Mandelbrot iteration generator and a streaming consumer,
// with frame/line markers. Define MANDELBROT_PALETTE_EN for the RGB222 palette.
module mandelbrot_pixel_buffer #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     gen_running,
  output logic                     gen_run,
  input  logic                     pix_valid,
  input  logic [3:0]               pix_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_data,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int DATA_W = 4;
  localparam int OUT_W  = 6;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pending;
  logic [XW-1:0]     x_o;
  logic [YW-1:0]     y_o;

  logic full;
  logic pop;
  logic push;
  logic drop;
  logic req;

  function automatic logic [OUT_W-1:0] colour_map(input logic [DATA_W-1:0] d);
`ifdef MANDELBROT_PALETTE_EN
    return {d[3:2], d[2:1], d[1:0]};
`else
    return {2'b00, d};
`endif
  endfunction

  assign full      = (level == FULL_LVL);
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes a pixel when the head leaves in the same cycle.
  assign push      = pix_valid & (~full | pop);
  assign drop      = pix_valid & full & ~pop;
  assign req       = enable & ~gen_running & ~pending & ~gen_run & (level < FULL_LVL);

  assign out_data  = colour_map(mem[rd_ptr]);
  assign out_sof   = (x_o == '0) && (y_o == '0);
  assign out_eol   = (x_o == X_LAST);

  // Control: request handshake, pointers, occupancy, raster position.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_run  <= 1'b0;
      pending  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      x_o      <= '0;
      y_o      <= '0;
    end else begin
      gen_run <= req;
      if (gen_run)
        pending <= 1'b1;
      else if (pix_valid)
        pending <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (drop) overflow <= 1'b1;

      if (pop) begin
        if (x_o == X_LAST) begin
          x_o <= '0;
          y_o <= (y_o == Y_LAST) ? '0 : y_o + 1'b1;
        end else begin
          x_o <= x_o + 1'b1;
        end
      end
    end
  end

  // Data storage: no reset, pixels coincident with rst are not stored.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= pix_data;
  end

endmodule
